msi_sender: RTL and testbench

//  Peripheral-side MSI transmitter: the initiator end of the msi_req/msi_code interface of the tile irq adapter.
//  - Edge-detects N_SRC interrupt sources and latches them as pending.
//  - Arbitrates pending sources by fixed priority and emits one-cycle MSI pulses.
//  - Throttles sends by watching the adapter's CPU-side irq request, so a code is never overwritten before the CPU acks it.

---
 rtl/msi_sender_if.sv | 10 +
 rtl/msi_sender.sv | 136 +++++++++++++
 tb/tb_msi_sender.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/msi_sender_if.sv
// MSI request/code bus between a peripheral-side sender and the tile irq adapter,
// together with the adapter's CPU-side irq level that the sender watches for throttling.
interface msi_sender_if;
    logic       msi_req_o;
    logic [7:0] msi_code_o;
    logic       irq_pending_i;

    modport master (output msi_req_o, output msi_code_o, input irq_pending_i);
    modport slave  (input msi_req_o, input msi_code_o, output irq_pending_i);
endinterface

// File: rtl/msi_sender.sv
// Peripheral-side MSI transmitter: edge-detects sources, arbitrates by fixed priority, throttles on the CPU irq.
// Optional sticky overflow flags are built only when MSI_SENDER_OVF_EN is defined.
module msi_sender #(
    parameter int         N_SRC        = 8,
    parameter logic [7:0] CODE_BASE    = 8'h10,
    parameter int         GAP_CYCLES   = 4,
    parameter int         HOLD_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_SRC-1:0] src_i,
    input  logic [N_SRC-1:0] mask_i,
    msi_sender_if.master     msi,
    output logic [N_SRC-1:0] pending_o,
    output logic             busy_o,
    output logic [N_SRC-1:0] ovf_o,
    input  logic [N_SRC-1:0] ovf_clr_i
);
    localparam int         SEL_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [7:0] TMO_LAST = 8'(HOLD_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, HOLD, GAP} state_e;

    state_e           state_q, state_d;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend_q, pend_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             seen_q, seen_d;

    logic [N_SRC-1:0] event_w;
    logic [N_SRC-1:0] eligible_w;
    logic [N_SRC-1:0] clr_w;
    logic [SEL_W-1:0] winner_w;
    logic             hold_done_w;

    assign event_w    = src_i & ~src_q;
    assign eligible_w = pend_q & mask_i;

    // Lowest eligible index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        winner_w = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (eligible_w[k]) winner_w = SEL_W'(k);
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        clr_w       = '0;
        hold_done_w = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible_w) begin
                    sel_d   = winner_w;
                    clr_w   = N_SRC'(1) << winner_w;
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = HOLD;
                cnt_d   = '0;
                seen_d  = 1'b0;
            end
            HOLD: begin
                // Once the CPU irq has been seen high, only its ack (fall) ends HOLD; no timeout then.
                if (seen_q) begin
                    if (!msi.irq_pending_i) hold_done_w = 1'b1;
                end else if (msi.irq_pending_i) begin
                    seen_d = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    hold_done_w = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (hold_done_w) begin
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) state_d = IDLE;
                else                   cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new event on the source being dispatched re-arms it, hence OR after the clear.
    assign pend_d = (pend_q & ~clr_w) | event_w;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            src_q   <= '0;
            pend_q  <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_i;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            seen_q  <= seen_d;
        end
    end

    assign msi.msi_req_o  = (state_q == SEND);
    assign msi.msi_code_o = (state_q == SEND) ? (CODE_BASE + 8'(sel_q)) : 8'h00;
    assign pending_o      = pend_q;
    assign busy_o         = (state_q != IDLE);

`ifdef MSI_SENDER_OVF_EN
    logic [N_SRC-1:0] ovf_q, ovf_d;

    // Set wins over a simultaneous clear; pending is sampled before this cycle's dispatch clear.
    assign ovf_d = (ovf_q & ~ovf_clr_i) | (event_w & pend_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ovf_q <= '0;
        else         ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ^ovf_clr_i;
    assign ovf_o          = '0;
`endif
endmodule

// File: tb/tb_msi_sender.sv
// Self-checking bench for msi_sender: directed scenarios plus randomized traffic against a timeline model.
module tb_msi_sender;
    localparam int         N    = 8;
    localparam logic [7:0] BASE = 8'h10;
    localparam int         GAP  = 4;
    localparam int         TMO  = 255;
    localparam int         OW   = 10 + 2 * N;
`ifdef MSI_SENDER_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] src, mask, ovf_clr;
    logic [N-1:0] pending, ovf;
    logic         busy;

    msi_sender_if bus();

    msi_sender #(.N_SRC(N), .CODE_BASE(BASE), .GAP_CYCLES(GAP), .HOLD_TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .src_i(src), .mask_i(mask), .msi(bus),
        .pending_o(pending), .busy_o(busy), .ovf_o(ovf), .ovf_clr_i(ovf_clr)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Adapter stand-in: raises the CPU irq the cycle after a request and drops it resp_len cycles later.
    bit resp_en = 1'b0;
    int resp_len = 5;
    int resp_left = 0;
    bit saw_req = 1'b0;

    // Reference model: pending as a vector, the in-flight transaction as a set of cycle stamps.
    int           m_cyc = 0, m_send_at = -1, m_release = -1, m_win;
    bit           m_txn = 1'b0, m_seen = 1'b0;
    logic [N-1:0] m_prev = '0, m_pend = '0, m_ovf = '0, m_ev, m_clr;
    logic [7:0]   m_code = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_send_at = -1; m_release = -1; m_txn = 1'b0; m_seen = 1'b0;
            m_prev = '0; m_pend = '0; m_ovf = '0; m_code = 8'h00;
        end else begin
            m_ev = src & ~m_prev;
            m_prev = src;
            m_clr = '0;
            if (!m_txn) begin
                m_win = -1;
                for (int k = 0; k < N; k++) if (m_win < 0 && m_pend[k] && mask[k]) m_win = k;
                if (m_win >= 0) begin
                    m_clr[m_win] = 1'b1;
                    m_txn = 1'b1; m_send_at = m_cyc + 1; m_release = -1; m_seen = 1'b0;
                    m_code = BASE + 8'(m_win);
                end
            end else if (m_release < 0 && m_cyc > m_send_at) begin
                if (m_seen) begin
                    if (!bus.irq_pending_i) m_release = m_cyc + 1;
                end else if (bus.irq_pending_i) m_seen = 1'b1;
                else if (m_cyc - m_send_at == TMO) m_release = m_cyc + 1;
            end
            if (m_txn && m_release >= 0 && m_cyc + 1 >= m_release + GAP) m_txn = 1'b0;
            if (OVF_EN) m_ovf = (m_ovf & ~ovf_clr) | (m_ev & m_pend);
            m_pend = (m_pend & ~m_clr) | m_ev;
            m_cyc++;
        end
    end

    function automatic logic [OW-1:0] expv();
        logic req;
        req = m_txn && (m_cyc == m_send_at);
        return {req, req ? m_code : 8'h00, m_txn, m_pend, m_ovf};
    endfunction

    function automatic logic [OW-1:0] actv();
        return {bus.msi_req_o, bus.msi_code_o, busy, pending, ovf};
    endfunction

    task automatic cycle();
        @(posedge clk); #1;
        if (resp_en) begin
            if (saw_req) begin
                bus.irq_pending_i = 1'b1;
                resp_left = resp_len;
            end else if (resp_left > 0) begin
                resp_left--;
                if (resp_left == 0) bus.irq_pending_i = 1'b0;
            end
        end
        saw_req = bus.msi_req_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; src = '0; mask = '1; ovf_clr = '0; bus.irq_pending_i = 1'b0;
        resp_en = 1'b0; resp_left = 0; saw_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (actv() !== '0) begin
            tests_failed++; $display("FAIL reset_hold got=%h exp=0", actv());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            tests_run++;
            if (actv() !== '0) begin
                tests_failed++; $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, actv());
            end
        end
    endtask

    task automatic test_single();
        int busy_n = 0;
        mask = '1; resp_en = 1'b1; resp_len = 5;
        src[2] = 1'b1;
        cycle();
        tests_run++;
        if (bus.msi_req_o !== 1'b0) begin
            tests_failed++; $display("FAIL single_early_req got=%b exp=0", bus.msi_req_o);
        end
        cycle();
        tests_run++;
        if ({bus.msi_req_o, bus.msi_code_o} !== {1'b1, 8'h12}) begin
            tests_failed++; $display("FAIL single_req got=%b/%h exp=1/12", bus.msi_req_o, bus.msi_code_o);
        end
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            tests_run++;
            if (actv() !== expv()) begin
                tests_failed++; $display("FAIL model_single cyc=%0d got=%h exp=%h", i, actv(), expv());
            end
            if (i == 1) src[2] = 1'b0;
            cycle();
        end
        tests_run++;
        if (busy_n != 1 + (1 + 5) + GAP) begin
            tests_failed++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_n, 1 + (1 + 5) + GAP);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] codes[$];
        int at[$];
        resp_en = 1'b1; resp_len = 5;
        src = 8'b0010_0010;
        for (int i = 0; i < 60; i++) begin
            cycle();
            tests_run++;
            if (actv() !== expv()) begin
                tests_failed++; $display("FAIL model_simul cyc=%0d got=%h exp=%h", i, actv(), expv());
            end
            if (bus.msi_req_o) begin codes.push_back(bus.msi_code_o); at.push_back(i); end
            if (i == 3) src = '0;
        end
        tests_run++;
        if (codes.size() != 2) begin
            tests_failed++; $display("FAIL simul_count got=%0d exp=2", codes.size());
        end else begin
            tests_run++;
            if (codes[0] !== 8'h11 || codes[1] !== 8'h15) begin
                tests_failed++; $display("FAIL simul_order got=%h,%h exp=11,15", codes[0], codes[1]);
            end
            if (at[1] - at[0] != 1 + (1 + 5) + GAP + 1) begin
                tests_failed++; $display("FAIL simul_spacing got=%0d exp=%0d", at[1] - at[0], 1 + (1 + 5) + GAP + 1);
            end
        end
    endtask

    task automatic test_timeout();
        int run = 0, second = -1;
        bit ended = 1'b0;
        logic [7:0] code2 = 8'h00;
        resp_en = 1'b0; bus.irq_pending_i = 1'b0;
        src[0] = 1'b1;
        cycle(); cycle();
        tests_run++;
        if ({bus.msi_req_o, bus.msi_code_o} !== {1'b1, 8'h10}) begin
            tests_failed++; $display("FAIL tmo_req got=%b/%h exp=1/10", bus.msi_req_o, bus.msi_code_o);
        end
        for (int i = 0; i < 560; i++) begin
            tests_run++;
            if (actv() !== expv()) begin
                tests_failed++; $display("FAIL model_tmo cyc=%0d got=%h exp=%h", i, actv(), expv());
            end
            if (!ended) begin
                if (busy) run++;
                else ended = 1'b1;
            end
            if (i > 0 && bus.msi_req_o && second < 0) begin second = i; code2 = bus.msi_code_o; end
            if (i == 1) src[0] = 1'b0;
            if (i == 5) src[6] = 1'b1;
            if (i == 8) src[6] = 1'b0;
            cycle();
        end
        tests_run++;
        if (run != 1 + TMO + GAP) begin
            tests_failed++; $display("FAIL tmo_busy_len got=%0d exp=%0d", run, 1 + TMO + GAP);
        end
        tests_run++;
        if (second != 1 + TMO + GAP + 1 || code2 !== BASE + 8'd6) begin
            tests_failed++; $display("FAIL tmo_next got=%0d/%h exp=%0d/16", second, code2, 1 + TMO + GAP + 1);
        end
    endtask

    task automatic test_mask();
        int reqcyc = -1;
        logic [7:0] c = 8'h00;
        resp_en = 1'b1; resp_len = 3;
        mask = 8'hF7; src[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            tests_run++;
            if (actv() !== expv() || bus.msi_req_o !== 1'b0) begin
                tests_failed++; $display("FAIL mask_held cyc=%0d got=%h exp=%h", i, actv(), expv());
            end
        end
        tests_run++;
        if (pending[3] !== 1'b1) begin
            tests_failed++; $display("FAIL mask_pending got=%b exp=1", pending[3]);
        end
        src[3] = 1'b0; mask = '1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            tests_run++;
            if (actv() !== expv()) begin
                tests_failed++; $display("FAIL model_mask cyc=%0d got=%h exp=%h", i, actv(), expv());
            end
            if (bus.msi_req_o && reqcyc < 0) begin reqcyc = i; c = bus.msi_code_o; end
        end
        tests_run++;
        if (reqcyc < 0 || reqcyc > 2 || c !== 8'h13) begin
            tests_failed++; $display("FAIL mask_release got=%0d/%h exp=<=2/13", reqcyc, c);
        end
    endtask

    task automatic test_overflow();
        int n14 = 0;
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        resp_en = 1'b1; resp_len = 2;
        mask = 8'hEF;
        for (int i = 0; i < 7; i++) begin
            src[4] = pat[i];
            cycle();
            tests_run++;
            if (actv() !== expv()) begin
                tests_failed++; $display("FAIL model_ovf cyc=%0d got=%h exp=%h", i, actv(), expv());
            end
        end
        tests_run++;
        if (ovf[4] !== OVF_EN || pending[4] !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_set got=%b/%b exp=%b/1", ovf[4], pending[4], OVF_EN);
        end
        mask = '1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (bus.msi_req_o && bus.msi_code_o == 8'h14) n14++;
        end
        tests_run++;
        if (n14 != 1 || ovf[4] !== OVF_EN) begin
            tests_failed++; $display("FAIL ovf_single_msi got=%0d/%b exp=1/%b", n14, ovf[4], OVF_EN);
        end
        ovf_clr[4] = 1'b1;
        cycle();
        ovf_clr = '0;
        tests_run++;
        if (ovf !== '0 || actv() !== expv()) begin
            tests_failed++; $display("FAIL ovf_clear got=%h exp=0", ovf);
        end
    endtask

    task automatic test_reset_mid();
        resp_en = 1'b1; resp_len = 4;
        src[7] = 1'b1;
        cycle(); cycle();
        tests_run++;
        if (busy !== 1'b1 || bus.msi_code_o !== 8'h17) begin
            tests_failed++; $display("FAIL midrst_send got=%b/%h exp=1/17", busy, bus.msi_code_o);
        end
        src[7] = 1'b0; src[1] = 1'b1;
        cycle(); cycle();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (actv() !== '0) begin
            tests_failed++; $display("FAIL midrst_async got=%h exp=0", actv());
        end
        bus.irq_pending_i = 1'b0; resp_left = 0; saw_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            tests_run++;
            if (actv() !== expv()) begin
                tests_failed++; $display("FAIL model_midrst cyc=%0d got=%h exp=%h", i, actv(), expv());
            end
        end
        src = '0;
    endtask

    task automatic test_random();
        resp_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0) src = src ^ (N'($urandom) & N'($urandom));
            mask = ($urandom_range(0, 5) == 0) ? N'($urandom) : '1;
            ovf_clr = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
            resp_len = $urandom_range(1, 6);
            cycle();
            if (!busy && resp_left == 0) bus.irq_pending_i = ($urandom_range(0, 9) == 0);
            tests_run++;
            if (actv() !== expv()) begin
                tests_failed++; $display("FAIL model_random cyc=%0d got=%h exp=%h", i, actv(), expv());
            end
        end
        src = '0; mask = '1; ovf_clr = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_timeout();
        test_mask();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
